// File: rtl/breath_pkg.sv
// Shared encodings for the breathing-LED sequencer: pattern modes, FSM states
// and the default brightness resolution.
package breath_pkg;

  localparam logic [1:0] MODE_OFF      = 2'd0;
  localparam logic [1:0] MODE_ALL      = 2'd1;
  localparam logic [1:0] MODE_CHASE    = 2'd2;
  localparam logic [1:0] MODE_PINGPONG = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_FALL = 2'd2;
  localparam logic [1:0] ST_NEXT = 2'd3;

  localparam int CNT_NUM_DEFAULT = 3464;

endpackage

// File: rtl/breath_pwm_core.sv
// Shared triangle-brightness generator: a PWM phase counter plus a level that
// climbs to the top and back down, one step per PWM period.
module breath_pwm_core
  import breath_pkg::*;
#(
  parameter int CNT_NUM = CNT_NUM_DEFAULT,
  parameter int CW      = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic at_top,
  output logic at_bottom,
  output logic step,
  output logic lit
);

  localparam logic [CW-1:0] TOP = CW'(CNT_NUM - 1);

  logic [CW-1:0] ph_reg;
  logic [CW-1:0] level_reg;
  logic          falling_reg;

  assign step      = run && (ph_reg == TOP);
  assign at_top    = (level_reg == TOP);
  assign at_bottom = (level_reg == '0);
  assign lit       = (ph_reg < level_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_reg      <= '0;
      level_reg   <= '0;
      falling_reg <= 1'b0;
    end else if (clr) begin
      ph_reg      <= '0;
      level_reg   <= '0;
      falling_reg <= 1'b0;
    end else if (run) begin
      ph_reg <= (ph_reg == TOP) ? '0 : ph_reg + 1'b1;
      if (step) begin
        // The top level is held for one extra period while turning round.
        if (!falling_reg) begin
          if (at_top) falling_reg <= 1'b1;
          else        level_reg   <= level_reg + 1'b1;
        end else if (!at_bottom) begin
          level_reg <= level_reg - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/breath_led_sched.sv
// Breathing-LED sequencer: FSM chooses which LED breathes and when the pattern
// advances; LED pins are driven active-low from a registered steering stage.
module breath_led_sched
  import breath_pkg::*;
#(
  parameter int N_LED   = 8,
  parameter int CNT_NUM = CNT_NUM_DEFAULT,
  parameter int CW      = 12,
  parameter int IW      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic [IW-1:0]    active_idx,
  output logic             cycle_done,
  output logic             busy
);

  localparam logic [IW-1:0] LAST = IW'(N_LED - 1);

  logic [1:0]       state_reg, state_next;
  logic [1:0]       mode_q_reg;
  logic [IW-1:0]    idx_reg, idx_adv;
  logic             dir_up_reg, dir_adv;
  logic [N_LED-1:0] led_reg, led_next;
  logic             run, clr, at_top, at_bottom, step, lit;

  assign run = en && (state_reg == ST_RISE || state_reg == ST_FALL);
  assign clr = !en || state_reg == ST_IDLE || state_reg == ST_NEXT;

  breath_pwm_core #(
    .CNT_NUM (CNT_NUM),
    .CW      (CW)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .clr       (clr),
    .at_top    (at_top),
    .at_bottom (at_bottom),
    .step      (step),
    .lit       (lit)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (en && mode != MODE_OFF) state_next = ST_RISE;
      ST_RISE: begin
        if (!en)                  state_next = ST_IDLE;
        else if (step && at_top)  state_next = ST_FALL;
      end
      ST_FALL: begin
        if (!en)                    state_next = ST_IDLE;
        else if (step && at_bottom) state_next = ST_NEXT;
      end
      default: state_next = (en && mode != MODE_OFF) ? ST_RISE : ST_IDLE;
    endcase
  end

  // Index advance uses the pattern that was running during the finished breath.
  always_comb begin
    idx_adv = idx_reg;
    dir_adv = dir_up_reg;
    if (N_LED > 1) begin
      case (mode_q_reg)
        MODE_CHASE: idx_adv = (idx_reg == LAST) ? '0 : idx_reg + 1'b1;
        MODE_PINGPONG: begin
          if (dir_up_reg) begin
            if (idx_reg == LAST) begin
              idx_adv = idx_reg - 1'b1;
              dir_adv = 1'b0;
            end else begin
              idx_adv = idx_reg + 1'b1;
            end
          end else begin
            if (idx_reg == '0) begin
              idx_adv = idx_reg + 1'b1;
              dir_adv = 1'b1;
            end else begin
              idx_adv = idx_reg - 1'b1;
            end
          end
        end
        default: idx_adv = idx_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LED; gi++) begin : g_led
      assign led_next[gi] = (run && (mode_q_reg == MODE_ALL ||
                             (mode_q_reg[1] && idx_reg == IW'(gi)))) ? ~lit : 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      mode_q_reg <= MODE_OFF;
      idx_reg    <= '0;
      dir_up_reg <= 1'b1;
      led_reg    <= '1;
    end else begin
      state_reg <= state_next;
      led_reg   <= led_next;
      if (state_reg == ST_IDLE && state_next == ST_RISE) begin
        mode_q_reg <= mode;
        idx_reg    <= '0;
        dir_up_reg <= 1'b1;
      end else if (state_reg == ST_NEXT) begin
        idx_reg    <= idx_adv;
        dir_up_reg <= dir_adv;
        mode_q_reg <= mode;
      end
    end
  end

  assign led        = led_reg;
  assign active_idx = idx_reg;
  assign cycle_done = (state_reg == ST_NEXT);
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_breath_led_sched.sv
// Directed bench for breath_led_sched with CNT_NUM = 4 on 8-, 4- and 1-LED
// instances sharing one stimulus; breath period is 33 clocks.
module tb_breath_led_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [7:0] led8;
  logic [2:0] idx8;
  logic       cd8, busy8;
  logic [3:0] led4;
  logic [1:0] idx4;
  logic       cd4, busy4;
  logic [0:0] led1;
  logic [0:0] idx1;
  logic       cd1, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  breath_led_sched #(.N_LED(8), .CNT_NUM(4), .CW(4), .IW(3)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .led(led8), .active_idx(idx8), .cycle_done(cd8), .busy(busy8));

  breath_led_sched #(.N_LED(4), .CNT_NUM(4), .CW(4), .IW(2)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .led(led4), .active_idx(idx4), .cycle_done(cd4), .busy(busy4));

  breath_led_sched #(.N_LED(1), .CNT_NUM(4), .CW(4), .IW(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .led(led1), .active_idx(idx1), .cycle_done(cd1), .busy(busy1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stop_run();
    en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    mode = 2'd2;
    en   = 1'b1;
    rst  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (led8 !== 8'hFF || idx8 !== 3'd0 || busy8 !== 1'b0 || cd8 !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: led=%h idx=%0d busy=%b cd=%b required led=ff idx=0 busy=0 cd=0",
                 led8, idx8, busy8, cd8);
      end
    end
    en   = 1'b0;
    mode = 2'd0;
    rst  = 1'b1;
    tick();
    total++;
    if (busy8 !== 1'b0 || led8 !== 8'hFF) begin
      bad++;
      $display("FAIL reset_release: busy=%b led=%h required busy=0 led=ff", busy8, led8);
    end
  endtask

  task automatic test_breath_timing();
    int   n;
    logic samp [1:33];
    int   low_all, low_peak, low_bot1, low_bot2;
    bit   uneven, early, bad_idx;
    mode = 2'd1;
    en   = 1'b1;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      tick();
      if (cd8) n = i;
    end
    total++;
    if (n != 33) begin
      bad++;
      $display("FAIL first_pulse: got tick %0d required 33", n);
    end
    uneven = 0; early = 0; bad_idx = 0;
    for (int i = 1; i <= 33; i++) begin
      tick();
      samp[i] = led8[0];
      if (led8 !== 8'h00 && led8 !== 8'hFF) uneven = 1;
      if (i < 33 && cd8 !== 1'b0) early = 1;
      if (idx8 !== 3'd0) bad_idx = 1;
    end
    total++;
    if (cd8 !== 1'b1 || early) begin
      bad++;
      $display("FAIL pulse_period: cd_at_33=%b early=%b required cd_at_33=1 early=0", cd8, early);
    end
    total++;
    if (uneven) begin
      bad++;
      $display("FAIL all_same_duty: leds differed, required identical");
    end
    total++;
    if (bad_idx) begin
      bad++;
      $display("FAIL mode1_idx: active_idx left 0, required 0");
    end
    low_all = 0; low_peak = 0; low_bot1 = 0; low_bot2 = 0;
    for (int i = 1; i <= 33; i++) begin
      if (samp[i] === 1'b0) low_all++;
      if (i >= 14 && i <= 17 && samp[i] === 1'b0) low_peak++;
      if (i >= 2 && i <= 5 && samp[i] === 1'b0) low_bot1++;
      if (i >= 30 && samp[i] === 1'b0) low_bot2++;
    end
    total++;
    if (low_all != 12) begin
      bad++;
      $display("FAIL lit_per_breath: got %0d required 12", low_all);
    end
    total++;
    if (low_peak != 3) begin
      bad++;
      $display("FAIL peak_duty: got %0d required 3", low_peak);
    end
    total++;
    if (low_bot1 != 0 || low_bot2 != 0) begin
      bad++;
      $display("FAIL bottom_dark: got rise=%0d fall=%0d required 0 0", low_bot1, low_bot2);
    end
    stop_run();
  endtask

  task automatic test_chase();
    int  exp_idx [5];
    bit  stray, seen_lit, timeout;
    exp_idx = '{0, 1, 2, 3, 0};
    stray = 0; seen_lit = 0;
    mode = 2'd2;
    en   = 1'b1;
    for (int p = 0; p < 5; p++) begin
      timeout = 1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if ((~led4 & ~(4'b0001 << idx4)) != 4'b0000) stray = 1;
        if (led4 != 4'hF) seen_lit = 1;
        if (cd4) begin
          timeout = 0;
          break;
        end
      end
      total++;
      if (timeout || idx4 !== 2'(exp_idx[p])) begin
        bad++;
        $display("FAIL chase_idx[%0d]: got %0d timeout=%b required %0d", p, idx4, timeout, exp_idx[p]);
      end
    end
    total++;
    if (stray || !seen_lit) begin
      bad++;
      $display("FAIL chase_only_active: stray=%b lit_seen=%b required 0 1", stray, seen_lit);
    end
    stop_run();
  endtask

  task automatic test_pingpong();
    int exp_idx [8];
    bit timeout;
    exp_idx = '{0, 1, 2, 3, 2, 1, 0, 1};
    mode = 2'd3;
    en   = 1'b1;
    for (int p = 0; p < 8; p++) begin
      timeout = 1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (cd4) begin
          timeout = 0;
          break;
        end
      end
      total++;
      if (timeout || idx4 !== 2'(exp_idx[p])) begin
        bad++;
        $display("FAIL pingpong_idx[%0d]: got %0d timeout=%b required %0d", p, idx4, timeout, exp_idx[p]);
      end
      total++;
      if (cd1 !== 1'b1 || idx1 !== 1'b0) begin
        bad++;
        $display("FAIL pingpong_n1[%0d]: cd=%b idx=%0d required cd=1 idx=0", p, cd1, idx1);
      end
    end
    stop_run();
  endtask

  task automatic test_mode_change();
    int n;
    bit dropped;
    mode = 2'd2;
    en   = 1'b1;
    n = 0; dropped = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      tick();
      if (i == 16) mode = 2'd0;
      if (cd8) n = i;
      else if (busy8 !== 1'b1) dropped = 1;
    end
    total++;
    if (n != 33 || dropped) begin
      bad++;
      $display("FAIL mode_change_pulse: got tick %0d dropped=%b required 33 0", n, dropped);
    end
    tick();
    total++;
    if (busy8 !== 1'b0 || led8 !== 8'hFF || cd8 !== 1'b0 || idx8 !== 3'd1) begin
      bad++;
      $display("FAIL mode_change_idle: busy=%b led=%h cd=%b idx=%0d required 0 ff 0 1",
               busy8, led8, cd8, idx8);
    end
  endtask

  task automatic test_en_drop();
    bit timeout, spurious;
    mode = 2'd2;
    en   = 1'b1;
    timeout = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cd8) begin
        timeout = 0;
        break;
      end
    end
    for (int i = 1; i <= 20; i++) tick();
    total++;
    if (timeout || idx8 !== 3'd1 || busy8 !== 1'b1) begin
      bad++;
      $display("FAIL en_drop_setup: timeout=%b idx=%0d busy=%b required 0 1 1", timeout, idx8, busy8);
    end
    en = 1'b0;
    tick();
    total++;
    if (busy8 !== 1'b0 || led8 !== 8'hFF || cd8 !== 1'b0) begin
      bad++;
      $display("FAIL en_drop_idle: busy=%b led=%h cd=%b required 0 ff 0", busy8, led8, cd8);
    end
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cd8 !== 1'b0 || busy8 !== 1'b0 || led8 !== 8'hFF) spurious = 1;
    end
    total++;
    if (spurious) begin
      bad++;
      $display("FAIL en_drop_quiet: activity seen while disabled, required none");
    end
    en = 1'b1;
    tick();
    total++;
    if (busy8 !== 1'b1 || idx8 !== 3'd0) begin
      bad++;
      $display("FAIL restart_idx: busy=%b idx=%0d required 1 0", busy8, idx8);
    end
    spurious = 0;
    for (int i = 2; i <= 5; i++) begin
      tick();
      if (led8 !== 8'hFF) spurious = 1;
    end
    total++;
    if (spurious) begin
      bad++;
      $display("FAIL restart_level0: led lit during first period, required dark");
    end
    tick();
    total++;
    if (led8 !== 8'hFE) begin
      bad++;
      $display("FAIL restart_level1_on: led=%h required fe", led8);
    end
    tick();
    total++;
    if (led8 !== 8'hFF) begin
      bad++;
      $display("FAIL restart_level1_off: led=%h required ff", led8);
    end
    stop_run();
  endtask

  task automatic test_async_reset();
    mode = 2'd1;
    en   = 1'b1;
    for (int i = 1; i <= 14; i++) tick();
    total++;
    if (led8 !== 8'h00 || busy8 !== 1'b1) begin
      bad++;
      $display("FAIL async_pre: led=%h busy=%b required 00 1", led8, busy8);
    end
    rst = 1'b0;
    #2;
    total++;
    if (led8 !== 8'hFF || busy8 !== 1'b0 || idx8 !== 3'd0 || cd8 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: led=%h busy=%b idx=%0d cd=%b required ff 0 0 0",
               led8, busy8, idx8, cd8);
    end
    en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_breath_timing();
    test_chase();
    test_pingpong();
    test_mode_change();
    test_en_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
